risc_v_mike_gpio_in: RTL
========================

RISC_V_MIKE_GPIO_IN -- requirements
Module: risc_v_mike_gpio_in

Interface
REQ-001 SHALL have parameter GPIO_BYTE, default 8: number of GPIO input pins.
REQ-002 SHALL have parameter DB_CNT, default 4: debounce stability window in cycles, legal range 2..255.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gpio_port_in  input  GPIO_BYTE  asynchronous external pins.
REQ-006 SHALL have port addr  input  4  word address: 0x0 DATA, 0x4 RISE, 0x8 FALL, 0xC MASK.
REQ-007 SHALL have port rd_en  input  1  read request, one cycle.
REQ-008 SHALL have port wr_en  input  1  write request, one cycle.
REQ-009 SHALL have port wr_data  input  32  write data; bits [GPIO_BYTE-1:0] used.
REQ-010 SHALL have port rd_data  output  32  read data, valid only while rd_valid is high.
REQ-011 SHALL have port rd_valid  output  1  read response strobe.
REQ-012 SHALL have port gpio_irq  output  1  level interrupt request.

Function
REQ-013 SHALL pass each pin through a 2-flop synchronizer.
REQ-014 SHALL keep one counter per bit; synced != filtered: counter increments; synced == filtered: counter clears.
REQ-015 SHALL update the filtered bit and clear its counter at the edge where the counter equals DB_CNT-1 and the mismatch persists; a pin held stable is reflected in filtered exactly 2+DB_CNT edges after it changes.
REQ-016 SHALL reject glitches shorter than DB_CNT synced cycles; the filtered bit stays unchanged.
REQ-017 SHALL set RISE[i] on a filtered 0->1 update and FALL[i] on a filtered 1->0 update, in the same cycle; both are sticky.
REQ-018 SHALL clear RISE/FALL bits by write-1; write-0 leaves the bit unchanged; set and clear of the same bit in one cycle: set wins.
REQ-019 SHALL make DATA read-only (returns filtered value); writes to DATA are ignored.
REQ-020 SHALL register reads: rd_valid is high the cycle after rd_en and low otherwise; rd_data is 0 when rd_valid is low.
REQ-021 SHALL zero-fill rd_data bits above GPIO_BYTE; unmapped or misaligned addresses read 0 and ignore writes.
REQ-022 SHALL return the pre-write value when rd_en and wr_en target the same address in one cycle.
REQ-023 SHALL accept back-to-back reads every cycle with no stall.

Reset
REQ-024 SHALL clear synchronizers, counters, filtered, RISE, FALL, MASK, rd_data, rd_valid and gpio_irq to 0 on rst.
REQ-025 SHALL abandon in-flight debounce and pending read response on reset asserted mid-operation; rd_valid is 0 the next cycle.
REQ-026 SHALL NOT flag an edge for pins already high at reset release; a high pin only sets RISE after debounce from filtered=0.

Configuration
REQ-027 SHALL use macro GPIO_IRQ_EN: when defined, MASK is read/write and gpio_irq is registered |((RISE|FALL)&MASK), one cycle after status/mask change.
REQ-028 SHALL, when GPIO_IRQ_EN is undefined, make MASK read 0 and ignore writes to it, and tie gpio_irq to 0.

Verification
REQ-029 SHALL cover: DB_CNT=4, pin0 0->1 held -> DATA=0x01 on edge 6 after change, RISE=0x01, FALL=0x00.
REQ-030 SHALL cover: pin3 pulse 3 cycles wide -> DATA stays 0x00, RISE=0x00, FALL=0x00.
REQ-031 SHALL cover: RISE=0x05, write 0x04 to 0x4 -> RISE reads 0x01; write-clear coinciding with new rise on bit0 -> bit0 stays 1.
REQ-032 SHALL cover (GPIO_IRQ_EN): MASK=0x02, rise on pin1 -> gpio_irq=1 next cycle; write 0x02 to RISE -> gpio_irq=0 next cycle; rise on pin0 only -> gpio_irq stays 0.
REQ-033 SHALL cover: rd_en on 0x0/0x4/0x8/0xC on consecutive cycles -> four consecutive rd_valid pulses with matching data; read 0x6 -> 0x00000000.
REQ-034 SHALL cover: rst asserted during debounce count 2 -> all outputs 0 next cycle, no RISE after release unless pin re-debounced.

Source files
------------

// File: rtl/risc_v_mike_gpio_in.sv
// Debounced GPIO input block: 2-flop sync, per-pin stability counter, sticky RISE/FALL status.
// Optional GPIO_IRQ_EN macro adds a read/write MASK and a registered level interrupt.
module risc_v_mike_gpio_in #(
  parameter int GPIO_BYTE = 8,
  parameter int DB_CNT    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [GPIO_BYTE-1:0] gpio_port_in,
  input  logic [3:0]           addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  output logic                 rd_valid,
  output logic                 gpio_irq
);

  localparam logic [7:0] CNT_TC = 8'(DB_CNT - 1);

  logic [GPIO_BYTE-1:0] sync1_q, sync2_q;
  logic [GPIO_BYTE-1:0] filt_q, filt_d;
  logic [GPIO_BYTE-1:0] rise_q, rise_d;
  logic [GPIO_BYTE-1:0] fall_q, fall_d;
  logic [GPIO_BYTE-1:0] upd;
  logic [GPIO_BYTE-1:0] mask_q;
  logic [GPIO_BYTE-1:0] wdat;
  logic [GPIO_BYTE-1:0] clr_rise, clr_fall;
  logic [7:0]           cnt_q [GPIO_BYTE];
  logic [7:0]           cnt_d [GPIO_BYTE];
  logic [31:0]          rd_word;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 unused_wr_hi;

  assign wdat         = wr_data[GPIO_BYTE-1:0];
  assign unused_wr_hi = ^wr_data;
  assign clr_rise     = (wr_en && addr == 4'h4) ? wdat : '0;
  assign clr_fall     = (wr_en && addr == 4'h8) ? wdat : '0;

  // A counter only runs while the synced pin disagrees with the filtered value.
  always_comb begin
    filt_d = filt_q;
    upd    = '0;
    for (int i = 0; i < GPIO_BYTE; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        cnt_d[i]  = '0;
        filt_d[i] = sync2_q[i];
        upd[i]    = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    rise_d = (rise_q & ~clr_rise) | (upd & sync2_q);
    fall_d = (fall_q & ~clr_fall) | (upd & ~sync2_q);
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      4'h0:    rd_word[GPIO_BYTE-1:0] = filt_q;
      4'h4:    rd_word[GPIO_BYTE-1:0] = rise_q;
      4'h8:    rd_word[GPIO_BYTE-1:0] = fall_q;
      4'hC:    rd_word[GPIO_BYTE-1:0] = mask_q;
      default: rd_word = '0;
    endcase
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_word : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < GPIO_BYTE; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= gpio_port_in;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < GPIO_BYTE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef GPIO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && addr == 4'hC) mask_q <= wdat;
      irq_q <= |((rise_q | fall_q) & mask_q);
    end
  end

  assign gpio_irq = irq_q;
`else
  assign mask_q   = '0;
  assign gpio_irq = 1'b0;
`endif

endmodule
